// File: rtl/memwb_pkg.sv
// Shared types and constants for the memory/writeback stage.
package memwb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WB
  } memwb_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } access_size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [6:0] OPC_LOAD = 7'h03;

  function automatic logic is_load_opcode(input logic [6:0] opcode);
    return opcode == OPC_LOAD;
  endfunction

  // Stores only know SB/SH; loads also have the unsigned byte/half forms.
  // Anything unrecognised is treated as a full word.
  function automatic access_size_e access_size(input logic store, input logic [2:0] funct3);
    access_size_e sz;
    sz = SZ_WORD;
    if (store) begin
      if (funct3 == F3_SB)      sz = SZ_BYTE;
      else if (funct3 == F3_SH) sz = SZ_HALF;
    end else begin
      if (funct3 == F3_LB || funct3 == F3_LBU)      sz = SZ_BYTE;
      else if (funct3 == F3_LH || funct3 == F3_LHU) sz = SZ_HALF;
    end
    return sz;
  endfunction

endpackage

// File: rtl/memory_writeback_load_align.sv
// Load data lane extraction and sign/zero extension (combinational).
module load_align
  import memwb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane, then extend according to funct3.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_writeback.sv
// Memory/writeback stage: issues loads/stores on a req/gnt/rvalid data port
// and writes ALU results or aligned load data to the register file.
// Optional: define MEMWB_MISALIGN_CHECK_EN to drop misaligned accesses and
// pulse misalign_err instead of silently aligning the address.
module memory_writeback
  import memwb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_s,
  input  logic            ex_i,
  input  logic            ex_load,
  input  logic [2:0]      ex_funct3,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_mem_address,
  input  logic [XLEN-1:0] ex_result,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            misalign_err
);

  memwb_state_e state_q, state_d;

  logic            store_q;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] data_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic [XLEN-1:0] load_data;
  access_size_e    size_q;

  logic xfer;
  logic is_mem_in;
  logic mis_in;

  assign xfer      = ex_valid && (state_q == S_IDLE);
  assign is_mem_in = ex_s | (ex_i & ex_load);

`ifdef MEMWB_MISALIGN_CHECK_EN
  access_size_e size_in;
  logic         misalign_q;

  assign size_in = access_size(ex_s, ex_funct3);
  assign mis_in  = is_mem_in &&
                   (((size_in == SZ_HALF) && ex_mem_address[0]) ||
                    ((size_in == SZ_WORD) && (ex_mem_address[1:0] != 2'b00)));

  // One-cycle pulse for an access dropped at the transfer.
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= xfer && mis_in;
  end

  assign misalign_err = misalign_q;
`else
  assign mis_in       = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d  = state_q;
    ex_ready = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        ex_ready = 1'b1;
        if (ex_valid && !mis_in) state_d = is_mem_in ? S_REQ : S_WB;
      end
      S_REQ: begin
        dmem_req = 1'b1;
        dmem_we  = store_q;
        if (dmem_gnt) state_d = store_q ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (dmem_rvalid) state_d = S_WB;
      end
      S_WB: begin
        rf_we   = (rd_q != '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the accepted instruction; register load data on rvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      store_q    <= 1'b0;
      f3_q       <= '0;
      rd_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rf_wdata_q <= '0;
    end else begin
      if (xfer) begin
        store_q <= ex_s;
        f3_q    <= ex_funct3;
        rd_q    <= ex_rd;
        addr_q  <= ex_mem_address;
        data_q  <= ex_result;
        if (!is_mem_in) rf_wdata_q <= ex_result;
      end
      if (state_q == S_WAIT && dmem_rvalid) rf_wdata_q <= load_data;
    end
  end

  assign size_q = access_size(store_q, f3_q);

  // Request address, store lanes and byte enables from the captured access.
  always_comb begin
    dmem_wstrb = '0;
    dmem_wdata = '0;
    case (size_q)
      SZ_BYTE: dmem_addr = addr_q;
      SZ_HALF: dmem_addr = {addr_q[XLEN-1:1], 1'b0};
      default: dmem_addr = {addr_q[XLEN-1:2], 2'b00};
    endcase
    if (store_q) begin
      case (size_q)
        SZ_BYTE: begin
          dmem_wstrb = 4'b0001 << addr_q[1:0];
          dmem_wdata = {(XLEN/8){data_q[7:0]}};
        end
        SZ_HALF: begin
          dmem_wstrb = 4'b0011 << {addr_q[1], 1'b0};
          dmem_wdata = {(XLEN/16){data_q[15:0]}};
        end
        default: begin
          dmem_wstrb = 4'b1111;
          dmem_wdata = data_q;
        end
      endcase
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata   (dmem_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .data    (load_data)
  );

  assign rf_waddr = rd_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_memory_writeback.sv
// Directed self-checking bench for memory_writeback.
module tb_memory_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_s, ex_i, ex_load;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic [31:0] ex_mem_address, ex_result;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        rf_we, misalign_err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int total = 0;
  int bad   = 0;

  memory_writeback #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_s(ex_s), .ex_i(ex_i),
    .ex_load(ex_load), .ex_funct3(ex_funct3), .ex_rd(ex_rd),
    .ex_mem_address(ex_mem_address), .ex_result(ex_result),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic s, input logic i, input logic ld, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] res);
    ex_valid = 1'b1; ex_s = s; ex_i = i; ex_load = ld; ex_funct3 = f3;
    ex_rd = rd; ex_mem_address = addr; ex_result = res;
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] res, input int gnt_delay,
                           input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                           input logic [31:0] exp_wdata);
    issue(1'b1, 1'b0, 1'b0, f3, 5'd3, addr, res);
    for (int k = 0; k <= gnt_delay; k++) begin
      chk({tag, ".req"},   32'(dmem_req), 32'd1);
      chk({tag, ".we"},    32'(dmem_we), 32'd1);
      chk({tag, ".addr"},  dmem_addr, exp_addr);
      chk({tag, ".wstrb"}, 32'(dmem_wstrb), 32'(exp_strb));
      chk({tag, ".wdata"}, dmem_wdata, exp_wdata);
      chk({tag, ".ready"}, 32'(ex_ready), 32'd0);
      if (k == gnt_delay) dmem_gnt = 1'b1;
      tick();
    end
    dmem_gnt = 1'b0;
    chk({tag, ".req_done"},   32'(dmem_req), 32'd0);
    chk({tag, ".ready_back"}, 32'(ex_ready), 32'd1);
    chk({tag, ".no_rfwe"},    32'(rf_we), 32'd0);
  endtask

  task automatic run_load(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] addr, input logic [31:0] exp_addr,
                          input logic [31:0] rdata, input int gap,
                          input logic exp_we, input logic [31:0] exp_data);
    issue(1'b0, 1'b1, 1'b1, f3, rd, addr, 32'h5555_5555);
    chk({tag, ".req"},   32'(dmem_req), 32'd1);
    chk({tag, ".we"},    32'(dmem_we), 32'd0);
    chk({tag, ".addr"},  dmem_addr, exp_addr);
    chk({tag, ".ready"}, 32'(ex_ready), 32'd0);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    for (int k = 0; k < gap; k++) begin
      chk({tag, ".wait_req"}, 32'(dmem_req), 32'd0);
      tick();
    end
    chk({tag, ".wait_ready"}, 32'(ex_ready), 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    tick();
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    chk({tag, ".rf_we"},    32'(rf_we), 32'(exp_we));
    chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(rd));
    chk({tag, ".rf_wdata"}, rf_wdata, exp_data);
    chk({tag, ".wb_ready"}, 32'(ex_ready), 32'd0);
    tick();
    chk({tag, ".rf_we_off"}, 32'(rf_we), 32'd0);
    chk({tag, ".ready_back"}, 32'(ex_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 0; ex_s = 0; ex_i = 0; ex_load = 0; ex_funct3 = '0; ex_rd = '0;
    ex_mem_address = '0; ex_result = '0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;
    tick();
    tick();

    // Reset state
    chk("rst.ex_ready",  32'(ex_ready), 32'd1);
    chk("rst.dmem_req",  32'(dmem_req), 32'd0);
    chk("rst.dmem_we",   32'(dmem_we), 32'd0);
    chk("rst.rf_we",     32'(rf_we), 32'd0);
    chk("rst.misalign",  32'(misalign_err), 32'd0);
    chk("rst.dmem_addr", dmem_addr, 32'd0);
    chk("rst.wdata",     dmem_wdata, 32'd0);
    chk("rst.wstrb",     32'(dmem_wstrb), 32'd0);
    chk("rst.rf_waddr",  32'(rf_waddr), 32'd0);
    chk("rst.rf_wdata",  rf_wdata, 32'd0);
    rst = 1'b0;
    tick();

    // ALU writeback: rf_we in N+1
    issue(1'b0, 1'b1, 1'b0, 3'b000, 5'd5, 32'h0, 32'h0000_1234);
    chk("alu.rf_we",    32'(rf_we), 32'd1);
    chk("alu.rf_waddr", 32'(rf_waddr), 32'd5);
    chk("alu.rf_wdata", rf_wdata, 32'h0000_1234);
    chk("alu.ready",    32'(ex_ready), 32'd0);
    chk("alu.no_req",   32'(dmem_req), 32'd0);
    tick();
    chk("alu.rf_we_off", 32'(rf_we), 32'd0);
    chk("alu.ready_back", 32'(ex_ready), 32'd1);

    // Stores
    run_store("sb", 3'b000, 32'h0000_0102, 32'h0000_00AB, 2, 32'h0000_0102, 4'b0100, 32'hABAB_ABAB);
    run_store("sh", 3'b001, 32'h0000_0006, 32'h1234_CDEF, 0, 32'h0000_0006, 4'b1100, 32'hCDEF_CDEF);
    run_store("sw", 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 1, 32'h0000_0008, 4'b1111, 32'hDEAD_BEEF);

    // Loads
    run_load("lb",    3'b000, 5'd7,  32'h0000_0203, 32'h0000_0203, 32'h80FF_FFFF, 0, 1'b1, 32'hFFFF_FF80);
    run_load("lbu",   3'b100, 5'd8,  32'h0000_0203, 32'h0000_0203, 32'h80FF_FFFF, 0, 1'b1, 32'h0000_0080);
    run_load("lh",    3'b001, 5'd10, 32'h0000_0002, 32'h0000_0002, 32'h7FFF_0000, 1, 1'b1, 32'h0000_7FFF);
    run_load("lh_r0", 3'b001, 5'd0,  32'h0000_0002, 32'h0000_0002, 32'h7FFF_0000, 1, 1'b0, 32'h0000_7FFF);
    run_load("lh_neg", 3'b001, 5'd11, 32'h0000_0010, 32'h0000_0010, 32'h1234_8001, 0, 1'b1, 32'hFFFF_8001);
    run_load("lhu",   3'b101, 5'd12, 32'h0000_0010, 32'h0000_0010, 32'h1234_8001, 0, 1'b1, 32'h0000_8001);
    run_load("lw",    3'b010, 5'd13, 32'h0000_0040, 32'h0000_0040, 32'hCAFE_F00D, 2, 1'b1, 32'hCAFE_F00D);

    // Reset while waiting for read data; late rvalid must be ignored
    issue(1'b0, 1'b1, 1'b1, 3'b010, 5'd9, 32'h0000_0020, 32'h0);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk("rstmid.in_wait", 32'(ex_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid.ready", 32'(ex_ready), 32'd1);
    chk("rstmid.req",   32'(dmem_req), 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1111_2222;
    tick();
    dmem_rvalid = 1'b0;
    chk("rstmid.rf_we",   32'(rf_we), 32'd0);
    chk("rstmid.ready2",  32'(ex_ready), 32'd1);
    tick();
    chk("rstmid.rf_we2",  32'(rf_we), 32'd0);

    // Misaligned word load at 0x101
`ifdef MEMWB_MISALIGN_CHECK_EN
    issue(1'b0, 1'b1, 1'b1, 3'b010, 5'd3, 32'h0000_0101, 32'h0);
    chk("mis.err",   32'(misalign_err), 32'd1);
    chk("mis.req",   32'(dmem_req), 32'd0);
    chk("mis.ready", 32'(ex_ready), 32'd1);
    tick();
    chk("mis.err_off", 32'(misalign_err), 32'd0);
    chk("mis.rf_we",   32'(rf_we), 32'd0);
    chk("mis.req2",    32'(dmem_req), 32'd0);
`else
    chk("mis.err_tied", 32'(misalign_err), 32'd0);
    run_load("mis_lw", 3'b010, 5'd3, 32'h0000_0101, 32'h0000_0100, 32'h0BAD_F00D, 0, 1'b1, 32'h0BAD_F00D);
    chk("mis.err_after", 32'(misalign_err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_writeback.md
# memory_writeback

Memory/writeback stage that consumes the Execute stage's results and completes each instruction. Loads and stores become byte-addressed requests on the data-memory port, using a request/grant/read-valid handshake. Load data is aligned and sign- or zero-extended. ALU results and load data are written to the register file. It holds off Execute with `ex_ready` while a memory access is outstanding.

## Interface
Parameters:
- `XLEN`, default 32: data and address width.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_valid` in 1: Execute presents an instruction.
- `ex_ready` out 1: stage accepts; transfer when `ex_valid & ex_ready`.
- `ex_s` in 1: store.
- `ex_i` in 1: I-type.
- `ex_load` in 1: I-type load (opcode 0x03); meaningful only with `ex_i`.
- `ex_funct3` in 3: access size/sign.
- `ex_rd` in 5: destination register (Execute `write_address`).
- `ex_mem_address` in XLEN: byte address.
- `ex_result` in XLEN: store data for stores; ALU/immediate result otherwise.
- `dmem_req` out 1: memory request.
- `dmem_we` out 1: 1 for a store.
- `dmem_addr` out XLEN: byte address.
- `dmem_wdata` out XLEN: lane-replicated store data.
- `dmem_wstrb` out 4: byte enables.
- `dmem_gnt` in 1: request accepted this cycle.
- `dmem_rvalid` in 1: read data valid.
- `dmem_rdata` in XLEN: read word.
- `rf_we` out 1: register-file write enable.
- `rf_waddr` out 5: register-file write address.
- `rf_wdata` out XLEN: register-file write data.
- `misalign_err` out 1: one-cycle pulse when an access is dropped (see Configuration).

## Operation
The stage is a four-state FSM: IDLE, REQ, WAIT, WB.
- **IDLE:**
  - `ex_ready`=1.
  - On a transfer, capture all `ex_*` inputs.
  - Store or load goes to REQ; anything else goes to WB.
- **REQ:**
  - `dmem_req`=1, with address, wdata and wstrb stable until `dmem_gnt`.
  - Store plus gnt goes to IDLE.
  - Load plus gnt goes to WAIT.
  - No gnt: stay in REQ.
- **WAIT:**
  - On `dmem_rvalid`, register the extended load data and go to WB.
  - Otherwise stay in WAIT.
- **WB:**
  - `rf_we`=1 for one cycle, with `rf_waddr`=rd.
  - Then go to IDLE.
  - If rd==0, `rf_we` stays 0.
- Store lanes:
  - SB (000): `wstrb`=0001<<addr[1:0], `wdata`={4{byte}}.
  - SH (001): `wstrb`=0011<<(2·addr[1]), `wdata`={2{half}}.
  - SW (010) and any other funct3: `wstrb`=1111.
- Load extract:
  - LB (000) and LBU (100) select the byte by addr[1:0], then sign- or zero-extend.
  - LH (001) and LHU (101) select the half by addr[1], then extend.
  - LW (010) and any other funct3 take the full word.
- `dmem_rvalid` outside WAIT is ignored. `dmem_gnt` outside REQ is ignored.

## Timing
- Reset values:
  - FSM=IDLE, so `ex_ready`=1.
  - `dmem_req`, `dmem_we`, `rf_we`, `misalign_err` = 0.
  - `dmem_addr`, `dmem_wdata`, `rf_waddr`, `rf_wdata` = 0.
  - `dmem_wstrb` = 0000.
- Latency, with the transfer at edge N:
  - ALU result: `rf_we` high in cycle N+1.
  - Store, grant on first request cycle: `dmem_req` high in N+1 only; `ex_ready` returns in N+2.
  - Load: `dmem_req` in N+1; rvalid no earlier than N+2; `rf_we` the cycle after rvalid (N+3 at minimum).
- Throughput: one instruction in flight; `ex_ready`=0 in REQ, WAIT and WB.
- `dmem_req` is never withdrawn before `dmem_gnt`, except by reset.
- Reset in REQ or WAIT forces IDLE. A late `rvalid` after reset is ignored.

## Configuration
- `MEMWB_MISALIGN_CHECK_EN` defined:
  - A misaligned access is detected in IDLE at the transfer: half access with addr[0]=1, or word access with addr[1:0]≠0.
  - Such an access issues no `dmem_req` and no `rf_we`.
  - `misalign_err` pulses in cycle N+1 and the FSM stays in IDLE.
- Undefined:
  - No check is made; `misalign_err` is tied 0.
  - Word accesses force `dmem_addr[1:0]`=00.
  - Half accesses ignore addr[0].

## Structure
- Package `memwb_pkg`:
  - FSM state enum.
  - funct3 constants (LB/LH/LW/LBU/LHU, SB/SH/SW).
  - `OPC_LOAD`=7'h03.
- Sub-module `load_align`: combinational extraction and extension from (rdata, addr[1:0], funct3); instantiated once.

## Test plan
- ALU writeback: `ex_i`=1, `ex_load`=0, rd=5, result=0x1234 -> `rf_we`=1, waddr=5, wdata=0x00001234 at N+1.
- Store byte with delayed grant: SB, addr=0x102, result=0xAB, gnt after 3 cycles -> req held 3 cycles, wstrb=0100, wdata=0xABABABAB, `ex_ready` low throughout.
- Signed and unsigned byte loads: LB, addr=0x203, rdata=0x80FFFFFF -> wdata=0xFFFFFF80; same access as LBU -> 0x00000080.
- Halfword load: LH, addr=0x2, rdata=0x7FFF0000, rvalid 2 cycles after gnt -> wdata=0x00007FFF; rd=0 variant -> `rf_we` never high.
- Reset mid-load: `rst` in WAIT, then rvalid -> no `rf_we`, FSM IDLE, `ex_ready`=1.
- Misalignment with `MEMWB_MISALIGN_CHECK_EN`: LW at 0x101 -> `misalign_err` pulse, no `dmem_req`; without the macro -> `dmem_addr`=0x100.
